serial_adder_ctrl: RTL and testbench
====================================

# serial_adder_ctrl

Bit-serial adder controller that sequences a single `f_adder` cell over a WIDTH-bit operand pair, one bit per clock, LSB first. It captures operands on a start request, runs the carry through a carry flip-flop, and assembles the sum in a shift register. It presents the result with a one-cycle `done` pulse. It sits between a register-level requester and the shared one-bit full-adder datapath, trading latency for area against a ripple adder.

## Interface
- `WIDTH`, default 8: operand and sum width in bits; legal range 1..32.
- `clk`  input  1  sole clock; all state updates on rising edge.
- `rst_n`  input  1  asynchronous, active-low reset; clears all state immediately on assertion.
- `start`  input  1  request; sampled only in IDLE.
- `a`  input  WIDTH  operand A; captured at the accepting edge.
- `b`  input  WIDTH  operand B; captured at the accepting edge.
- `cin`  input  1  carry-in; captured at the accepting edge.
- `busy`  output  1  high while in RUN.
- `done`  output  1  one-cycle completion pulse; high only in DONE.
- `sum`  output  WIDTH  result register; holds the last completed sum.
- `cout`  output  1  result carry-out; holds the last completed carry.

## Operation
- Exactly one `f_adder` instance. Inputs: `x` = sra[0], `y` = srb[0], `cin` = carry FF.
- Internal state:
  - operand shift registers sra and srb, WIDTH bits each
  - carry FF
  - partial-sum shift register srs, WIDTH bits
  - bit counter, ceil(log2(WIDTH))+1 bits
  - FSM
- FSM states: IDLE, RUN, DONE.
- IDLE, `start`=1:
  - sra←a, srb←b, carry←cin, count←0, srs←0.
  - Next state RUN.
- IDLE, `start`=0: stay in IDLE.
- RUN, every edge:
  - srs←{s, srs[WIDTH-1:1]}.
  - sra and srb shift right by one, filling with 0.
  - carry←f_adder cout, count←count+1.
- RUN, edge where count==WIDTH-1:
  - `sum`←{s, srs[WIDTH-1:1]}, `cout`←f_adder cout.
  - Next state DONE.
- DONE: one cycle, then unconditionally back to IDLE.
- `start` in RUN or DONE is ignored and is not queued. The requester must re-assert it in IDLE.
- Changes on `a`, `b`, `cin` after the accepting edge have no effect on the running operation.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). No overflow flag.
- `sum` and `cout` change only at the final RUN edge and otherwise hold their value across IDLE, new starts and RUN.

## Timing
- Reset values:
  - state IDLE, `busy`=0, `done`=0
  - `sum`=0, `cout`=0
  - all internal registers 0
- Reset asserted mid-RUN or in DONE aborts the operation. No `done` is produced, and outputs return to their reset values.
- Let the accepting edge be E0.
  - RUN occupies edges E1..EWIDTH; `busy`=1 from E0 up to EWIDTH.
  - `done`=1 from EWIDTH to EWIDTH+1.
  - `sum` and `cout` are valid from EWIDTH onward.
- Latency is WIDTH cycles, start edge to done.
- Throughput: minimum start-to-start spacing is WIDTH+2 cycles, because DONE→IDLE costs one cycle and the next start is sampled in IDLE.
- WIDTH=1 case:
  - RUN lasts exactly one edge; done is visible one cycle after E0.
  - The counter width still works: count==0 triggers the exit.
- `busy` and `done` are never high in the same cycle.

## Test plan
- WIDTH=8, a=0x5A, b=0x33, cin=0, one-cycle start:
  - `busy` high 8 cycles, then `done` pulse.
  - sum=0x8D, cout=0.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
- Start 0x10+0x20. Change a, b and cin to 0xAA, 0x55, 1 on the cycle after E0, and hold `start` high throughout RUN:
  - result is 0x30, cout=0, with exactly one `done` pulse.
  - a new run begins only on the first IDLE cycle.
- Assert `rst_n`=0 at RUN cycle 4, asynchronously between edges:
  - `busy`, `done`, `sum` and `cout` go to 0 immediately.
  - after release, no stale `done` appears and a new start works normally.
- WIDTH=1, all 8 combinations of a, b, cin: {cout,sum} matches a+b+cin, and `done` arrives one cycle after start.
- 1000 random back-to-back operations at WIDTH=8 and WIDTH=16, started as soon as IDLE is reached:
  - every {cout,sum} equals a+b+cin
  - `sum` and `cout` stay stable between done pulses

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: feeds one f_adder cell LSB first over WIDTH
// cycles, keeps the carry in a flop and assembles the sum in a shift register.

module f_adder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s_c,
  output logic cout_c
);

  assign s_c    = x ^ y ^ cin;
  assign cout_c = (x & y) | (x & cin) | (y & cin);

endmodule

module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   sra, sra_nxt;
  logic [WIDTH-1:0]   srb, srb_nxt;
  logic [WIDTH-1:0]   srs, srs_nxt;
  logic [CNT_W-1:0]   count, count_nxt;
  logic               carry, carry_nxt;
  logic [WIDTH-1:0]   sum_nxt;
  logic               cout_nxt;
  logic               busy_nxt;
  logic               done_nxt;
  logic               fa_s;
  logic               fa_cout;
  logic [WIDTH-1:0]   srs_shift;

  f_adder u_fa (
    .x     (sra[0]),
    .y     (srb[0]),
    .cin   (carry),
    .s_c   (fa_s),
    .cout_c(fa_cout)
  );

  // New sum bit enters at the MSB; written as shifts so WIDTH=1 needs no slice.
  assign srs_shift = (srs >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sra   <= '0;
      srb   <= '0;
      srs   <= '0;
      count <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      sra   <= sra_nxt;
      srb   <= srb_nxt;
      srs   <= srs_nxt;
      count <= count_nxt;
      carry <= carry_nxt;
      sum   <= sum_nxt;
      cout  <= cout_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sra_nxt   = sra;
    srb_nxt   = srb;
    srs_nxt   = srs;
    count_nxt = count;
    carry_nxt = carry;
    sum_nxt   = sum;
    cout_nxt  = cout;

    case (state)
      IDLE: begin
        if (start) begin
          sra_nxt   = a;
          srb_nxt   = b;
          carry_nxt = cin;
          count_nxt = '0;
          srs_nxt   = '0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        srs_nxt   = srs_shift;
        sra_nxt   = sra >> 1;
        srb_nxt   = srb >> 1;
        carry_nxt = fa_cout;
        count_nxt = count + CNT_W'(1);
        if (count == CNT_W'(WIDTH - 1)) begin
          sum_nxt   = srs_shift;
          cout_nxt  = fa_cout;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Status flags are registered decodes of the upcoming state.
    busy_nxt = (state_nxt == RUN);
    done_nxt = (state_nxt == DONE);
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random checks of serial_adder_ctrl at WIDTH=1, 8 and 16,
// sharing one clock and operand bus with per-instance start lines.

module tb_serial_adder_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a, b;
  logic        cin;
  logic        start1, start8, start16;
  logic        busy1, busy8, busy16;
  logic        done1, done8, done16;
  logic [0:0]  sum1;
  logic [7:0]  sum8;
  logic [15:0] sum16;
  logic        cout1, cout8, cout16;

  int checks   = 0;
  int failures = 0;
  logic [31:0] last_sum  [3];
  logic        last_cout [3];

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a[0:0]), .b(b[0:0]), .cin(cin),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1));
  serial_adder_ctrl #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a[7:0]), .b(b[7:0]), .cin(cin),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8));
  serial_adder_ctrl #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a[15:0]), .b(b[15:0]), .cin(cin),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16));

  function automatic int ix(input int w);
    return (w == 1) ? 0 : (w == 8) ? 1 : 2;
  endfunction

  function automatic logic [31:0] get_busy(input int w);
    return (w == 1) ? 32'(busy1) : (w == 8) ? 32'(busy8) : 32'(busy16);
  endfunction

  function automatic logic [31:0] get_done(input int w);
    return (w == 1) ? 32'(done1) : (w == 8) ? 32'(done8) : 32'(done16);
  endfunction

  function automatic logic [31:0] get_sum(input int w);
    return (w == 1) ? 32'(sum1) : (w == 8) ? 32'(sum8) : 32'(sum16);
  endfunction

  function automatic logic [31:0] get_cout(input int w);
    return (w == 1) ? 32'(cout1) : (w == 8) ? 32'(cout8) : 32'(cout16);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input int w, input logic v);
    start1  = (w == 1)  ? v : 1'b0;
    start8  = (w == 8)  ? v : 1'b0;
    start16 = (w == 16) ? v : 1'b0;
  endtask

  // One-cycle start pulse; returns at the negedge right after the accepting edge.
  task automatic start_op(input int w, input logic [31:0] av, input logic [31:0] bv,
                          input logic ci);
    @(negedge clk);
    a = av; b = bv; cin = ci;
    set_start(w, 1'b1);
    @(negedge clk);
    set_start(w, 1'b0);
  endtask

  task automatic run_op(input int w, input logic [31:0] av, input logic [31:0] bv,
                        input logic ci);
    logic [32:0] mask, full;
    int          lat, nbusy;
    logic        stable;
    mask = (33'h1 << w) - 33'h1;
    full = (33'(av) & mask) + (33'(bv) & mask) + 33'(ci);
    start_op(w, av, bv, ci);
    lat = 0; nbusy = 0; stable = 1'b1;
    while (get_done(w) != 32'd1 && lat < 64) begin
      if (get_busy(w) == 32'd1) nbusy++;
      if (get_sum(w) !== last_sum[ix(w)] || get_cout(w) !== 32'(last_cout[ix(w)]))
        stable = 1'b0;
      @(negedge clk);
      lat++;
    end
    check("latency",     32'(lat),   32'(w));
    check("busy_cycles", 32'(nbusy), 32'(w));
    check("busy_at_done", get_busy(w), 32'd0);
    check("result_stable", 32'(stable), 32'd1);
    check("sum",  get_sum(w),  32'(full & mask));
    check("cout", get_cout(w), 32'(full[w]));
    last_sum[ix(w)]  = 32'(full & mask);
    last_cout[ix(w)] = full[w];
  endtask

  initial begin
    int          ndone;
    int          lat;
    logic [2:0]  v;

    rst_n = 1'b0; a = '0; b = '0; cin = 1'b0;
    start1 = 1'b0; start8 = 1'b0; start16 = 1'b0;
    for (int i = 0; i < 3; i++) begin last_sum[i] = '0; last_cout[i] = 1'b0; end
    repeat (2) @(negedge clk);
    foreach (last_sum[i]) begin
      int w;
      w = (i == 0) ? 1 : (i == 1) ? 8 : 16;
      check("rst_busy", get_busy(w), 32'd0);
      check("rst_done", get_done(w), 32'd0);
      check("rst_sum",  get_sum(w),  32'd0);
      check("rst_cout", get_cout(w), 32'd0);
    end
    rst_n = 1'b1;

    // Directed WIDTH=8 vectors
    run_op(8, 32'h5A, 32'h33, 1'b0);
    run_op(8, 32'hFF, 32'h01, 1'b0);
    run_op(8, 32'hFF, 32'hFF, 1'b1);

    // Operand changes after acceptance and a held start are both ignored mid-run
    @(negedge clk);
    a = 32'h10; b = 32'h20; cin = 1'b0; start8 = 1'b1;
    @(negedge clk);
    a = 32'hAA; b = 32'h55; cin = 1'b1;
    ndone = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    check("hold_done_count", 32'(ndone), 32'd1);
    check("hold_idle_busy",  32'(busy8), 32'd0);
    check("hold_sum",  32'(sum8),  32'h30);
    check("hold_cout", 32'(cout8), 32'd0);
    @(negedge clk);
    start8 = 1'b0;
    check("hold_restart_busy", 32'(busy8), 32'd1);
    check("hold_sum_kept", 32'(sum8), 32'h30);
    lat = 0;
    while (!done8 && lat < 64) begin @(negedge clk); lat++; end
    check("hold2_latency", 32'(lat), 32'd8);
    check("hold2_sum",  32'(sum8),  32'h00);
    check("hold2_cout", 32'(cout8), 32'd1);

    // Asynchronous reset in the middle of a run
    start_op(8, 32'h12, 32'h34, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy8), 32'd0);
    check("arst_done", 32'(done8), 32'd0);
    check("arst_sum",  32'(sum8),  32'd0);
    check("arst_cout", 32'(cout8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    check("arst_no_stale_done", 32'(ndone), 32'd0);
    last_sum[1] = '0; last_cout[1] = 1'b0;
    run_op(8, 32'h80, 32'h7F, 1'b1);

    // Exhaustive WIDTH=1
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      run_op(1, 32'(v[0]), 32'(v[1]), v[2]);
    end

    // Random back-to-back operations
    repeat (1000) run_op(8,  $urandom, $urandom, 1'($urandom));
    repeat (1000) run_op(16, $urandom, $urandom, 1'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
